// File: rtl/coproc_pkg.sv
// Shared constants for the coprocessor instruction decoder: opcodes, field positions, geometry,
// bank IDs and the decoder state type.
package coproc_pkg;

   localparam int unsigned DIM = 5;
   localparam int unsigned EW  = 8;
   localparam int unsigned IW  = 22;
   localparam int unsigned AW  = 5;

   // Instruction word: {E1, E0, ID, LIN, COL, OP}
   localparam int unsigned OP_LSB  = 0;
   localparam int unsigned OP_MSB  = 3;
   localparam int unsigned COL_LSB = 4;
   localparam int unsigned COL_MSB = 6;
   localparam int unsigned LIN_LSB = 7;
   localparam int unsigned LIN_MSB = 9;
   localparam int unsigned ID_LSB  = 10;
   localparam int unsigned ID_MSB  = 11;
   localparam int unsigned E0_LSB  = 12;
   localparam int unsigned E0_MSB  = 16;
   localparam int unsigned E1_LSB  = 17;
   localparam int unsigned E1_MSB  = 21;

   localparam logic [3:0] OP_NOP        = 4'h0;
   localparam logic [3:0] OP_READ       = 4'h1;
   localparam logic [3:0] OP_WRITE      = 4'h2;
   localparam logic [3:0] OP_EXEC_FIRST = 4'h3;
   localparam logic [3:0] OP_SCALAR     = 4'h8;
   localparam logic [3:0] OP_DET_FIRST  = 4'h9;
   localparam logic [3:0] OP_EXEC_LAST  = 4'hC;

   localparam logic [1:0] BANK_A = 2'd0;
   localparam logic [1:0] BANK_B = 2'd1;
   localparam logic [1:0] BANK_C = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StWr0,
      StWr1,
      StRd0,
      StRd1,
      StRd2,
      StExec
   } state_e;

endpackage

// File: rtl/instr_field_unpack.sv
// Combinational unpacking of a latched instruction: field slicing, element sign-extension,
// linear index with range checks and the ALU argument.
module instr_field_unpack
   import coproc_pkg::*;
#(
   parameter int unsigned Dim = DIM,
   parameter int unsigned Ew  = EW
) (
   input  logic [IW-1:0] instr,
   output logic [3:0]    op,
   output logic [1:0]    id,
   output logic [Ew-1:0] e0_ext,
   output logic [Ew-1:0] e1_ext,
   output logic [AW-1:0] idx,
   output logic [AW-1:0] idx_nxt,
   output logic          idx_ok,
   output logic          idx_nxt_ok,
   output logic [7:0]    alu_arg
);

   logic [2:0] lin;
   logic [2:0] col;
   logic [4:0] e0;
   logic [4:0] e1;
   logic [7:0] idx_w;
   logic [7:0] idx_nxt_w;

   assign op  = instr[OP_MSB:OP_LSB];
   assign col = instr[COL_MSB:COL_LSB];
   assign lin = instr[LIN_MSB:LIN_LSB];
   assign id  = instr[ID_MSB:ID_LSB];
   assign e0  = instr[E0_MSB:E0_LSB];
   assign e1  = instr[E1_MSB:E1_LSB];

   assign e0_ext = {{(Ew-5){e0[4]}}, e0};
   assign e1_ext = {{(Ew-5){e1[4]}}, e1};

   // Index is formed wide so LIN/COL combinations beyond the matrix never alias a legal address.
   assign idx_w      = ({5'd0, lin} * 8'(Dim)) + {5'd0, col};
   assign idx_nxt_w  = idx_w + 8'd1;
   assign idx_ok     = idx_w < 8'(Dim * Dim);
   assign idx_nxt_ok = idx_nxt_w < 8'(Dim * Dim);
   assign idx        = idx_w[AW-1:0];
   assign idx_nxt    = idx_nxt_w[AW-1:0];

   always_comb begin
      alu_arg = 8'h00;
      if (op == OP_SCALAR) begin
         alu_arg = instr[ID_MSB:COL_LSB];
      end else if (op >= OP_DET_FIRST && op <= OP_EXEC_LAST) begin
         alu_arg = {4'h0, op - 4'd7};
      end
   end

endmodule

// File: rtl/coproc_instr_decoder.sv
// Host instruction receiver: latches one instruction per accept pulse and sequences bank
// writes/reads and ALU dispatch. ILLEGAL_OP_TRAP_EN turns opcodes 1101..1111 into error traps.
module coproc_instr_decoder
   import coproc_pkg::*;
#(
   parameter int unsigned Dim = DIM,
   parameter int unsigned Ew  = EW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] instr,
   input  logic          instr_valid,
   output logic          busy,
   output logic          mem_we,
   output logic [1:0]    mem_sel,
   output logic [AW-1:0] mem_addr,
   output logic [Ew-1:0] mem_wdata,
   input  logic [Ew-1:0] mem_rdata,
   output logic          alu_start,
   output logic [3:0]    alu_op,
   output logic [7:0]    alu_arg,
   input  logic          alu_done,
   input  logic [15:0]   alu_result,
   output logic [15:0]   result_out,
   output logic          err
);

   state_e        state_q, state_d;
   logic          pend_q, pend_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          mem_we_q, mem_we_d;
   logic [1:0]    mem_sel_q, mem_sel_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [Ew-1:0] mem_wdata_q, mem_wdata_d;
   logic          alu_start_q, alu_start_d;
   logic [3:0]    alu_op_q, alu_op_d;
   logic [7:0]    alu_arg_q, alu_arg_d;
   logic [Ew-1:0] lo_q, lo_d;
   logic [15:0]   result_q, result_d;
   logic          err_q, err_d;

   logic [3:0]    f_op;
   logic [1:0]    f_id;
   logic [Ew-1:0] f_e0, f_e1, rd_hi;
   logic [AW-1:0] f_idx, f_idx_nxt;
   logic          f_idx_ok, f_idx_nxt_ok;
   logic [7:0]    f_arg;

   instr_field_unpack #(
      .Dim (Dim),
      .Ew  (Ew)
   ) u_unpack (
      .instr      (instr_q),
      .op         (f_op),
      .id         (f_id),
      .e0_ext     (f_e0),
      .e1_ext     (f_e1),
      .idx        (f_idx),
      .idx_nxt    (f_idx_nxt),
      .idx_ok     (f_idx_ok),
      .idx_nxt_ok (f_idx_nxt_ok),
      .alu_arg    (f_arg)
   );

   assign rd_hi = f_idx_nxt_ok ? mem_rdata : '0;

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      instr_d     = instr_q;
      mem_we_d    = 1'b0;
      mem_sel_d   = mem_sel_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      alu_start_d = 1'b0;
      alu_op_d    = alu_op_q;
      alu_arg_d   = alu_arg_q;
      lo_d        = lo_q;
      result_d    = result_q;
      err_d       = err_q;

      // Only an idle decoder with nothing waiting for decode may take a new instruction.
      if (instr_valid) begin
         if (state_q == StIdle && !pend_q) begin
            instr_d = instr;
            pend_d  = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (pend_q) begin
               pend_d = 1'b0;
               if (f_op == OP_READ) begin
                  state_d    = StRd0;
                  mem_sel_d  = f_id;
                  mem_addr_d = f_idx;
               end else if (f_op == OP_WRITE) begin
                  state_d     = StWr0;
                  mem_sel_d   = f_id;
                  mem_addr_d  = f_idx;
                  mem_wdata_d = f_e0;
                  mem_we_d    = f_idx_ok;
                  if (!f_idx_ok) begin
                     err_d = 1'b1;
                  end
               end else if (f_op >= OP_EXEC_FIRST && f_op <= OP_EXEC_LAST) begin
                  state_d     = StExec;
                  alu_start_d = 1'b1;
                  alu_op_d    = f_op;
                  alu_arg_d   = f_arg;
               end
`ifdef ILLEGAL_OP_TRAP_EN
               else if (f_op > OP_EXEC_LAST) begin
                  err_d    = 1'b1;
                  result_d = 16'hEEE0 | {12'h000, f_op};
               end
`endif
            end
         end
         StWr0: begin
            state_d     = StWr1;
            mem_we_d    = f_idx_ok && f_idx_nxt_ok;
            mem_addr_d  = f_idx_nxt;
            mem_wdata_d = f_e1;
         end
         StWr1: state_d = StIdle;
         StRd0: begin
            state_d    = StRd1;
            mem_addr_d = f_idx_nxt;
         end
         StRd1: begin
            state_d = StRd2;
            lo_d    = f_idx_ok ? mem_rdata : '0;
         end
         StRd2: begin
            state_d  = StIdle;
            result_d = 16'({rd_hi, lo_q});
         end
         StExec: begin
            if (alu_done) begin
               result_d = alu_result;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pend_q      <= 1'b0;
         instr_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_sel_q   <= BANK_A;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         alu_start_q <= 1'b0;
         alu_op_q    <= OP_NOP;
         alu_arg_q   <= '0;
         lo_q        <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         instr_q     <= instr_d;
         mem_we_q    <= mem_we_d;
         mem_sel_q   <= mem_sel_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         alu_start_q <= alu_start_d;
         alu_op_q    <= alu_op_d;
         alu_arg_q   <= alu_arg_d;
         lo_q        <= lo_d;
         result_q    <= result_d;
         err_q       <= err_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign mem_we     = mem_we_q;
   assign mem_sel    = mem_sel_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign alu_start  = alu_start_q;
   assign alu_op     = alu_op_q;
   assign alu_arg    = alu_arg_q;
   assign result_out = result_q;
   assign err        = err_q;

endmodule

// File: tb/tb_coproc_instr_decoder.sv
// Randomized self-checking bench for coproc_instr_decoder with a behavioural bank/ALU model.
module tb_coproc_instr_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [21:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        busy, mem_we, alu_start, err;
   logic [1:0]  mem_sel;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_wdata, alu_arg;
   logic [7:0]  mem_rdata = 8'h00;
   logic [3:0]  alu_op;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = 16'h0000;
   logic [15:0] result_out;

   always #5 clk = ~clk;

   coproc_instr_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .busy        (busy),
      .mem_we      (mem_we),
      .mem_sel     (mem_sel),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .alu_start   (alu_start),
      .alu_op      (alu_op),
      .alu_arg     (alu_arg),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .result_out  (result_out),
      .err         (err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bank model: registered read, written on strobes; every strobe is logged.
   typedef struct {
      int sel;
      int addr;
      int data;
      int cyc;
   } wr_t;

   logic [7:0] bank [4][32] = '{default: '{default: 8'h00}};
   wr_t        wq[$];
   int         cyc = 0;

   always @(posedge clk) begin
      wr_t w;
      cyc <= cyc + 1;
      mem_rdata <= bank[mem_sel][mem_addr];
      if (mem_we) begin
         bank[mem_sel][mem_addr] <= mem_wdata;
         w.sel  = int'(mem_sel);
         w.addr = int'(mem_addr);
         w.data = int'(mem_wdata);
         w.cyc  = cyc;
         wq.push_back(w);
      end
   end

   // ALU model: completes alu_delay cycles after a start; not cleared by rst on purpose.
   int          alu_delay = 1;
   logic [15:0] alu_val = 16'h0000;
   int          starts = 0;
   int          cd = 0;
   logic [3:0]  op_at_start = '0;
   logic [7:0]  arg_at_start = '0;

   always @(posedge clk) begin
      alu_done <= 1'b0;
      if (alu_start) begin
         starts       <= starts + 1;
         cd           <= alu_delay;
         op_at_start  <= alu_op;
         arg_at_start <= alu_arg;
      end else if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) begin
            alu_done   <= 1'b1;
            alu_result <= alu_val;
         end
      end
   end

   // Reference state
   int          ref_mem [4][32];
   logic        m_err = 1'b0;
   logic [15:0] m_res = 16'h0000;

   function automatic logic [21:0] mk(input int e1, input int e0, input int id, input int lin,
                                      input int col, input int op);
      return {5'(e1), 5'(e0), 2'(id), 3'(lin), 3'(col), 4'(op)};
   endfunction

   task automatic issue(input logic [21:0] w);
      @(negedge clk);
      instr       = w;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      m_err = 1'b0;
      m_res = 16'h0000;
   endtask

   task automatic wait_idle(output int bcnt);
      bcnt = 0;
      @(negedge clk);
      while (busy && bcnt < 100) begin
         bcnt++;
         @(negedge clk);
      end
      check_eq("idle_timeout", busy, 1'b0);
   endtask

   task automatic run_instr(input logic [21:0] w, input logic [15:0] aval, input int adly);
      int  op, id, lin, col, idx, e0, e1, bcnt, st0, exp_busy;
      wr_t exp_q[$];
      wr_t x;
      op  = int'(w[3:0]);
      col = int'(w[6:4]);
      lin = int'(w[9:7]);
      id  = int'(w[11:10]);
      e0  = int'(w[16:12]);
      e1  = int'(w[21:17]);
      idx = lin * 5 + col;
      alu_val   = aval;
      alu_delay = adly;
      wq.delete();
      st0 = starts;
      issue(w);
      wait_idle(bcnt);
      exp_busy = -1;
      if (op == 2) begin
         exp_busy = 2;
         if (idx <= 24) begin
            x.sel = id; x.addr = idx; x.data = e0 | ((e0 >= 16) ? 8'hE0 : 8'h00);
            exp_q.push_back(x);
            if (idx + 1 <= 24) begin
               x.addr = idx + 1; x.data = e1 | ((e1 >= 16) ? 8'hE0 : 8'h00);
               exp_q.push_back(x);
            end
         end else begin
            m_err = 1'b1;
         end
         foreach (exp_q[i]) ref_mem[exp_q[i].sel][exp_q[i].addr] = exp_q[i].data;
      end else if (op == 1) begin
         exp_busy = 3;
         m_res = 16'((((idx + 1 <= 24) ? ref_mem[id][idx + 1] : 0) * 256) +
                     ((idx <= 24) ? ref_mem[id][idx] : 0));
      end else if (op >= 3 && op <= 12) begin
         m_res = aval;
         check_eq("alu_starts", starts - st0, 1);
         check_eq("alu_op", op_at_start, op);
         check_eq("alu_arg", arg_at_start,
                  (op == 8) ? int'(w[11:4]) : ((op >= 9) ? op - 7 : 0));
      end else begin
         exp_busy = 0;
`ifdef ILLEGAL_OP_TRAP_EN
         if (op >= 13) begin
            m_err = 1'b1;
            m_res = 16'hEEE0 | 16'(op);
         end
`endif
      end
      if (exp_busy >= 0) check_eq("busy_cycles", bcnt, exp_busy);
      check_eq("write_count", wq.size(), exp_q.size());
      if (wq.size() == exp_q.size()) begin
         foreach (exp_q[i]) begin
            check_eq("write_sel", wq[i].sel, exp_q[i].sel);
            check_eq("write_addr", wq[i].addr, exp_q[i].addr);
            check_eq("write_data", wq[i].data, exp_q[i].data);
         end
         if (wq.size() == 2) check_eq("write_gap", wq[1].cyc - wq[0].cyc, 1);
      end
      check_eq("result_out", result_out, m_res);
      check_eq("err", err, m_err);
   endtask

   task automatic check_reset_state();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_sel", mem_sel, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_alu_start", alu_start, 0);
      check_eq("rst_alu_op", alu_op, 0);
      check_eq("rst_alu_arg", alu_arg, 0);
      check_eq("rst_result", result_out, 0);
      check_eq("rst_err", err, 0);
   endtask

   initial begin
      int st0, bcnt, lin, col;
      foreach (ref_mem[i, j]) ref_mem[i][j] = 0;
      do_reset();
      check_reset_state();

      // Write E1=-8, E0=4 into bank B at element 0
      run_instr(mk(-8, 4, 1, 0, 0, 2), 16'h0, 1);
      // Preload A[0]=1, A[1]=2 then read it back
      run_instr(mk(2, 1, 0, 0, 0, 2), 16'h0, 1);
      run_instr(mk(0, 0, 0, 0, 0, 1), 16'h0, 1);
      check_eq("read_0201", result_out, 16'h0201);
      // Last element: single strobe, no error
      run_instr(mk(3, 7, 2, 4, 4, 2), 16'h0, 1);
      run_instr(mk(0, 0, 2, 4, 4, 1), 16'h0, 1);
      // ALU dispatch with a 7-cycle latency
      run_instr(mk(0, 0, 0, 0, 0, 3), 16'h1234, 7);
      check_eq("alu_1234", result_out, 16'h1234);
      // Unused opcode
      run_instr(mk(0, 0, 0, 0, 0, 15), 16'h0, 1);

      // New instruction arriving during EXEC is dropped and flags an error
      alu_val = 16'h5A5A; alu_delay = 7; wq.delete(); st0 = starts;
      issue(mk(1, 1, 0, 0, 0, 5));
      repeat (3) @(negedge clk);
      instr = mk(1, 1, 0, 1, 1, 2);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      wait_idle(bcnt);
      m_err = 1'b1; m_res = 16'h5A5A;
      check_eq("drop_starts", starts - st0, 1);
      check_eq("drop_writes", wq.size(), 0);
      check_eq("drop_err", err, 1);
      check_eq("drop_result", result_out, 16'h5A5A);

      // Randomized traffic; err must remain sticky across it
      for (int n = 0; n < 80; n++) begin
         lin = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 4);
         col = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 4);
         run_instr(mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3), lin,
                      col, $urandom_range(0, 15)), 16'($urandom), $urandom_range(1, 6));
      end
      check_eq("err_sticky", err, 1);

      do_reset();
      check_reset_state();

      // Reset in the middle of EXEC: the late alu_done must be ignored
      alu_val = 16'hBEEF; alu_delay = 8;
      issue(mk(0, 0, 0, 0, 0, 9));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; m_res = 16'h0000; m_err = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_result", result_out, 16'h0000);
      check_eq("abort_err", err, 0);
      run_instr(mk(5, 9, 3, 2, 3, 2), 16'h0, 1);
      run_instr(mk(0, 0, 3, 2, 3, 1), 16'h0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
